// File: rtl/fxp_pkg.sv
// Shared Q8.8 fixed-point constants and the feeder state encoding for the loss path.
package fxp_pkg;
  localparam int          FXP_W    = 16;
  localparam int          FXP_FRAC = 8;
  localparam logic [15:0] FXP_TWO  = 16'h0200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_READY = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/loss_feeder_if.sv
// Y-buffer write, batch config, activation stream and loss_child-facing outputs of one lane.
interface loss_feeder_if
  import fxp_pkg::*;
#(
  parameter int AW = 4
);
  logic             y_wr_en;
  logic [AW-1:0]    y_wr_addr;
  logic [FXP_W-1:0] y_wr_data;
  logic             cfg_valid;
  logic [AW:0]      cfg_batch_size;
  logic [FXP_W-1:0] H_in;
  logic             H_valid_in;
  logic [FXP_W-1:0] H_out;
  logic [FXP_W-1:0] Y_out;
  logic             valid_out;
  logic [FXP_W-1:0] inv_batch_size_times_two_out;
  logic             busy;
  logic             batch_done;
  logic             err;

  modport master (
    output y_wr_en, y_wr_addr, y_wr_data, cfg_valid, cfg_batch_size, H_in, H_valid_in,
    input  H_out, Y_out, valid_out, inv_batch_size_times_two_out, busy, batch_done, err
  );

  modport slave (
    input  y_wr_en, y_wr_addr, y_wr_data, cfg_valid, cfg_batch_size, H_in, H_valid_in,
    output H_out, Y_out, valid_out, inv_batch_size_times_two_out, busy, batch_done, err
  );
endinterface

// File: rtl/recip_div.sv
// Iterative restoring divider computing 2.0/divisor in Q8.8, one quotient bit per cycle.
module recip_div
  import fxp_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DW-1:0]    divisor_i,
  output logic [FXP_W-1:0] quotient_o,
  output logic             done_o
);
  logic [FXP_W-1:0] dvd_q, quo_q;
  logic [DW-2:0]    rem_q, rem_d;
  logic [4:0]       cnt_q;
  logic [DW-1:0]    trial;
  logic             ge;

  // Remainder stays below divisor (<= 2**(DW-1)), so DW-1 bits hold it
  assign trial      = {rem_q, dvd_q[FXP_W-1]};
  assign ge         = (trial >= divisor_i);
  assign rem_d      = ge ? (DW-1)'(trial - divisor_i) : (DW-1)'(trial);
  assign quotient_o = {quo_q[FXP_W-2:0], ge};
  assign done_o     = (cnt_q == 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      dvd_q <= FXP_TWO;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= 5'd16;
    end else if (cnt_q != 5'd0) begin
      dvd_q <= {dvd_q[FXP_W-2:0], 1'b0};
      quo_q <= quotient_o;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 5'd1;
    end
  end
endmodule

// File: rtl/loss_feeder.sv
// Buffers one batch of targets, pairs each activation with its target, and supplies 2/N.
module loss_feeder
  import fxp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic         clk,
  input logic         rst,
  loss_feeder_if.slave bus
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DIV   = ST_DIV;
  localparam logic [1:0] S_READY = ST_READY;

  logic [1:0]       state_q, state_d;
  logic [AW:0]      n_q, n_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FXP_W-1:0] h_q, h_d, y_q, y_d, inv_q, inv_d;
  logic             valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic [FXP_W-1:0] ybuf_q [DEPTH];
  logic             div_start, div_done, pair, last, n_ok;
  logic [FXP_W-1:0] div_quo;

  recip_div #(.DW(AW+1)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .divisor_i (n_q),
    .quotient_o(div_quo),
    .done_o    (div_done)
  );

  // Storage survives reset so a batch's targets can be reloaded without rewriting
  always_ff @(posedge clk) begin
    if (bus.y_wr_en) ybuf_q[bus.y_wr_addr] <= bus.y_wr_data;
  end

  assign pair = (state_q == S_READY) && bus.H_valid_in;
  assign last = ({1'b0, rd_ptr_q} == n_q - 1'b1);
  assign n_ok = (bus.cfg_batch_size != '0) && (int'(bus.cfg_batch_size) <= DEPTH);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rd_ptr_d  = rd_ptr_q;
    h_d       = h_q;
    y_d       = y_q;
    inv_d     = inv_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    div_start = 1'b0;
    if (pair) begin
      h_d      = bus.H_in;
      y_d      = ybuf_q[rd_ptr_q];
      valid_d  = 1'b1;
      done_d   = last;
      rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
    end
    if (bus.H_valid_in && state_q != S_READY) err_d = 1'b1;
    if (bus.cfg_valid) begin
      if (state_q == S_DIV || !n_ok) begin
        err_d = 1'b1;
      end else begin
        n_d       = bus.cfg_batch_size;
        rd_ptr_d  = '0;
        state_d   = S_DIV;
        div_start = 1'b1;
      end
    end
    if (state_q == S_DIV && div_done) begin
      state_d = S_READY;
      inv_d   = div_quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      rd_ptr_q <= '0;
      h_q      <= '0;
      y_q      <= '0;
      inv_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      rd_ptr_q <= rd_ptr_d;
      h_q      <= h_d;
      y_q      <= y_d;
      inv_q    <= inv_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.H_out                        = h_q;
  assign bus.Y_out                        = y_q;
  assign bus.valid_out                    = valid_q;
  assign bus.batch_done                   = done_q;
  assign bus.inv_batch_size_times_two_out = inv_q;
  assign bus.err                          = err_q;
  assign bus.busy                         = (state_q == S_DIV);
endmodule

// File: tb/tb_loss_feeder.sv
// Directed-vector bench for loss_feeder with hand-computed expected values.
module tb_loss_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  loss_feeder_if #(.AW(4)) bus ();

  loss_feeder #(.DEPTH(16), .AW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [4:0] n, output int busy_cycles);
    bus.cfg_valid      = 1'b1;
    bus.cfg_batch_size = n;
    tick();
    bus.cfg_valid = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic wr_y(input logic [3:0] a, input logic [15:0] d);
    bus.y_wr_en   = 1'b1;
    bus.y_wr_addr = a;
    bus.y_wr_data = d;
    tick();
    bus.y_wr_en = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] h);
    bus.H_valid_in = 1'b1;
    bus.H_in       = h;
    tick();
    bus.H_valid_in = 1'b0;
  endtask

  logic [15:0] hv [5] = '{16'h0180, 16'h0200, 16'h0000, 16'h0080, 16'h1234};
  logic [15:0] yv [5] = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0100};
  logic [4:0]  cfg_n  [4] = '{5'd4, 5'd3, 5'd1, 5'd16};
  logic [15:0] cfg_inv[4] = '{16'h0080, 16'h00AA, 16'h0200, 16'h0020};

  initial begin
    int bc;
    bus.y_wr_en = 0; bus.y_wr_addr = 0; bus.y_wr_data = 0;
    bus.cfg_valid = 0; bus.cfg_batch_size = 0;
    bus.H_in = 0; bus.H_valid_in = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_h_out", 32'(bus.H_out), 0);
    chk("rst_y_out", 32'(bus.Y_out), 0);
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_inv", 32'(bus.inv_batch_size_times_two_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.batch_done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_state", 32'(dut.state_q), 0);

    for (int i = 0; i < 4; i++) begin
      do_cfg(cfg_n[i], bc);
      chk($sformatf("cfg%0d_busy_len", cfg_n[i]), 32'(bc), 16);
      chk($sformatf("cfg%0d_inv", cfg_n[i]), 32'(bus.inv_batch_size_times_two_out), 32'(cfg_inv[i]));
      chk($sformatf("cfg%0d_state", cfg_n[i]), 32'(dut.state_q), 2);
    end

    wr_y(4'd0, 16'h0100);
    wr_y(4'd1, 16'h0200);
    wr_y(4'd2, 16'hFF00);
    wr_y(4'd3, 16'h0080);
    do_cfg(5'd4, bc);
    for (int i = 0; i < 5; i++) begin
      send_h(hv[i]);
      chk($sformatf("pair%0d_h", i), 32'(bus.H_out), 32'(hv[i]));
      chk($sformatf("pair%0d_y", i), 32'(bus.Y_out), 32'(yv[i]));
      chk($sformatf("pair%0d_valid", i), 32'(bus.valid_out), 1);
      chk($sformatf("pair%0d_done", i), 32'(bus.batch_done), (i == 3) ? 1 : 0);
    end
    tick();
    chk("idle_valid", 32'(bus.valid_out), 0);
    chk("idle_h_hold", 32'(bus.H_out), 32'h1234);
    chk("idle_y_hold", 32'(bus.Y_out), 32'h0100);
    chk("no_err_yet", 32'(bus.err), 0);

    do_cfg(5'd0, bc);
    chk("n0_err", 32'(bus.err), 1);
    chk("n0_busy", 32'(bc), 0);
    chk("n0_inv", 32'(bus.inv_batch_size_times_two_out), 32'h0080);
    chk("n0_n", 32'(dut.n_q), 4);
    do_cfg(5'd17, bc);
    chk("n17_busy", 32'(bc), 0);
    chk("n17_inv", 32'(bus.inv_batch_size_times_two_out), 32'h0080);
    chk("n17_n", 32'(dut.n_q), 4);
    chk("n17_state", 32'(dut.state_q), 2);

    bus.cfg_valid = 1'b1; bus.cfg_batch_size = 5'd4;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (7) tick();
    chk("mid_div_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_err", 32'(bus.err), 0);
    chk("arst_inv", 32'(bus.inv_batch_size_times_two_out), 0);
    chk("arst_h", 32'(bus.H_out), 0);
    chk("arst_y", 32'(bus.Y_out), 0);
    chk("arst_state", 32'(dut.state_q), 0);
    tick();
    rst = 1'b0;
    tick();
    do_cfg(5'd2, bc);
    chk("cfg2_busy_len", 32'(bc), 16);
    chk("cfg2_inv", 32'(bus.inv_batch_size_times_two_out), 32'h0100);

    bus.cfg_valid = 1'b1; bus.cfg_batch_size = 5'd4;
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    chk("pre_drop_err", 32'(bus.err), 0);
    send_h(16'h0777);
    chk("drop_valid", 32'(bus.valid_out), 0);
    chk("drop_err", 32'(bus.err), 1);
    bc = 0;
    while (bus.busy && bc < 40) begin bc++; tick(); end
    chk("drop_div_end", 32'(bus.busy), 0);
    chk("drop_inv", 32'(bus.inv_batch_size_times_two_out), 32'h0080);

    send_h(16'h0001);
    chk("col_y0", 32'(bus.Y_out), 32'h0100);
    send_h(16'h0002);
    chk("col_y1", 32'(bus.Y_out), 32'h0200);
    bus.y_wr_en = 1'b1; bus.y_wr_addr = 4'd2; bus.y_wr_data = 16'h0300;
    send_h(16'h0003);
    bus.y_wr_en = 1'b0;
    chk("col_y2_old", 32'(bus.Y_out), 32'hFF00);
    send_h(16'h0004);
    chk("col_y3", 32'(bus.Y_out), 32'h0080);
    chk("col_done", 32'(bus.batch_done), 1);
    send_h(16'h0005);
    send_h(16'h0006);
    send_h(16'h0007);
    chk("col_y2_new", 32'(bus.Y_out), 32'h0300);
    chk("col_h", 32'(bus.H_out), 32'h0007);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
